// File: rtl/core_step_controller.sv
// Execution-rate controller: produces the core clock-enable (halt / free / 1 Hz / single-step)
// from clk_100mhz, and exports the 1 ms and 1 s enable ticks.
module core_step_controller #(
    parameter int unsigned MS_DIV      = 100000,
    parameter int unsigned SEC_DIV_MS  = 1000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             halt_req,
    input  logic             step_btn,
    output logic             core_ce,
    output logic             tick_1ms,
    output logic             tick_1s,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       state
);

    localparam int unsigned MS_W  = (MS_DIV > 1)      ? $clog2(MS_DIV)      : 1;
    localparam int unsigned SEC_W = (SEC_DIV_MS > 1)  ? $clog2(SEC_DIV_MS)  : 1;
    localparam int unsigned DB_W  = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_FREE = 2'b01,
        S_SLOW = 2'b10,
        S_STEP = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_ce_next;
    logic             r_core_ce;
    logic [CNT_W-1:0] r_step_count;

    logic [MS_W-1:0]  r_ms_cnt;
    logic [SEC_W-1:0] r_sec_cnt;
    logic             r_tick_1ms;
    logic             r_tick_1s;
    logic             w_ms_wrap;
    logic             w_sec_last;

    logic             r_sync1;
    logic             r_sync2;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_btn_db;
    logic             r_btn_db_d;
    logic             w_step_pulse;

    assign w_ms_wrap  = (r_ms_cnt == MS_W'(MS_DIV - 1));
    assign w_sec_last = (r_sec_cnt == SEC_W'(SEC_DIV_MS - 1));

    // tick_1s is registered alongside the tick_1ms that wraps sec_cnt, so both rise together.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_ms_cnt   <= '0;
            r_sec_cnt  <= '0;
            r_tick_1ms <= 1'b0;
            r_tick_1s  <= 1'b0;
        end else begin
            r_tick_1ms <= w_ms_wrap;
            r_tick_1s  <= w_ms_wrap && w_sec_last;
            r_ms_cnt   <= w_ms_wrap ? '0 : r_ms_cnt + 1'b1;
            if (r_tick_1ms) begin
                r_sec_cnt <= w_sec_last ? '0 : r_sec_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
        end else begin
            r_sync1    <= step_btn;
            r_sync2    <= r_sync1;
            r_btn_db_d <= r_btn_db;
            if (r_tick_1ms) begin
                if (r_sync2 != r_btn_db) begin
                    // the DEBOUNCE_MS-th consecutive differing sample accepts the new level
                    if (r_db_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                        r_btn_db <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end
        end
    end

    assign w_step_pulse = r_btn_db & ~r_btn_db_d;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_state      <= S_HALT;
            r_core_ce    <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_core_ce    <= w_ce_next;
            r_step_count <= r_step_count + CNT_W'(r_core_ce);
        end
    end

    // Events are judged against the current state; halt_req suppresses event-driven enables.
    always_comb begin
        w_state_next = halt_req ? S_HALT : state_t'(mode);
        w_ce_next    = 1'b0;
        case (r_state)
            S_FREE:  w_ce_next = 1'b1;
            S_SLOW:  w_ce_next = r_tick_1s & ~halt_req;
            S_STEP:  w_ce_next = w_step_pulse & ~halt_req;
            default: w_ce_next = 1'b0;
        endcase
    end

    assign core_ce    = r_core_ce;
    assign tick_1ms   = r_tick_1ms;
    assign tick_1s    = r_tick_1s;
    assign step_count = r_step_count;
    assign state      = r_state;

endmodule

// File: tb/tb_core_step_controller.sv
// Scoreboarded bench for core_step_controller using small prescaler/debounce parameters.
module tb_core_step_controller;

    localparam int unsigned MS_DIV      = 10;
    localparam int unsigned SEC_DIV_MS  = 5;
    localparam int unsigned DEBOUNCE_MS = 3;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SEC_PERIOD  = MS_DIV * SEC_DIV_MS;

    logic             clk_100mhz = 1'b0;
    logic             rst        = 1'b1;
    logic [1:0]       mode       = 2'b00;
    logic             halt_req   = 1'b0;
    logic             step_btn   = 1'b0;
    logic             core_ce;
    logic             tick_1ms;
    logic             tick_1s;
    logic [CNT_W-1:0] step_count;
    logic [1:0]       state;

    core_step_controller #(
        .MS_DIV      (MS_DIV),
        .SEC_DIV_MS  (SEC_DIV_MS),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .mode       (mode),
        .halt_req   (halt_req),
        .step_btn   (step_btn),
        .core_ce    (core_ce),
        .tick_1ms   (tick_1ms),
        .tick_1s    (tick_1s),
        .step_count (step_count),
        .state      (state)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct packed {
        logic             ce;
        logic             ms;
        logic             s;
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned ec;
    int unsigned n_checks;
    int unsigned n_pass;
    logic [1:0]       m_state;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ce;

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
        ec++;
    endtask

    function automatic obs_t sample();
        return {core_ce, tick_1ms, tick_1s, state, step_count};
    endfunction

    task automatic model_reset();
        m_state = 2'b00;
        m_cnt   = '0;
        m_ce    = 1'b0;
        exp_q.delete();
    endtask

    // Predicts the outputs after the coming edge from the inputs now applied.
    // step_ev: the debounced button rises during the coming cycle.
    task automatic predict(input logic step_ev);
        int unsigned n;
        logic ce;
        obs_t e;
        n = ec + 1;
        case (m_state)
            2'b01:   ce = 1'b1;
            2'b10:   ce = (ec % SEC_PERIOD == 0) && (ec != 0) && !halt_req;
            2'b11:   ce = step_ev && !halt_req;
            default: ce = 1'b0;
        endcase
        m_cnt   = m_cnt + CNT_W'(m_ce);
        m_ce    = ce;
        m_state = halt_req ? 2'b00 : mode;
        e = {ce, (n % MS_DIV == 0), (n % SEC_PERIOD == 0), m_state, m_cnt};
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        obs_t got;
        #12;
        got = sample();
        n_checks++;
        if (got !== obs_t'(0))
            $display("FAIL reset_state got %b want %b", got, obs_t'(0));
        else n_pass++;
        @(negedge clk_100mhz);
        rst = 1'b0;
        ec  = 0;
        model_reset();
    endtask

    task automatic test_ticks();
        obs_t got, want;
        while (ec < 100) begin
            predict(1'b0);
            tick();
            got = sample(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want)
                $display("FAIL ticks edge %0d got %b want %b", ec, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_free();
        obs_t got, want;
        while (ec < 125) begin
            if (ec == 100) mode = 2'b01;
            if (ec == 122) mode = 2'b00;
            predict(1'b0);
            tick();
            got = sample(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want)
                $display("FAIL free edge %0d got %b want %b", ec, got, want);
            else n_pass++;
            if (ec == 118 || ec == 122) begin
                n_checks++;
                if (step_count !== ((ec == 118) ? 4'd0 : 4'd4))
                    $display("FAIL free_wrap edge %0d got %0d want %0d", ec, step_count,
                             (ec == 118) ? 0 : 4);
                else n_pass++;
            end
        end
    endtask

    task automatic test_halt_free();
        obs_t got, want;
        while (ec < 137) begin
            if (ec == 125) mode = 2'b01;
            if (ec == 129) halt_req = 1'b1;
            if (ec == 133) halt_req = 1'b0;
            if (ec == 135) mode = 2'b00;
            predict(1'b0);
            tick();
            got = sample(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want)
                $display("FAIL halt_free edge %0d got %b want %b", ec, got, want);
            else n_pass++;
            if (ec == 133) begin
                n_checks++;
                if (step_count !== 4'd10 || core_ce !== 1'b0)
                    $display("FAIL halt_frozen got cnt=%0d ce=%b want cnt=10 ce=0", step_count, core_ce);
                else n_pass++;
            end
        end
    endtask

    task automatic test_slow();
        obs_t got, want;
        int unsigned pulses;
        pulses = 0;
        while (ec < 402) begin
            if (ec == 137) mode = 2'b10;
            if (ec == 350) halt_req = 1'b1;
            if (ec == 355) halt_req = 1'b0;
            predict(1'b0);
            tick();
            got = sample(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want)
                $display("FAIL slow edge %0d got %b want %b", ec, got, want);
            else n_pass++;
            if (ec <= 337 && core_ce === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 4)
            $display("FAIL slow_pulses got %0d want 4", pulses);
        else n_pass++;
    endtask

    task automatic test_step_debounce();
        obs_t got, want;
        int unsigned pulses;
        pulses = 0;
        while (ec < 560) begin
            if (ec == 402) mode = 2'b11;
            if (ec == 412 || ec == 435 || ec == 465) step_btn = 1'b1;
            if (ec == 427 || ec == 453 || ec == 515) step_btn = 1'b0;
            predict(ec == 491);
            tick();
            got = sample(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want)
                $display("FAIL step edge %0d got %b want %b", ec, got, want);
            else n_pass++;
            if (core_ce === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1)
            $display("FAIL step_pulses got %0d want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        obs_t got, want;
        while (ec < 575) begin
            if (ec == 560) mode = 2'b10;
            predict(1'b0);
            tick();
            got = sample(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want)
                $display("FAIL pre_reset edge %0d got %b want %b", ec, got, want);
            else n_pass++;
        end
        #3;
        rst      = 1'b1;
        step_btn = 1'b1;
        mode     = 2'b11;
        #1;
        got = sample();
        n_checks++;
        if (got !== obs_t'(0))
            $display("FAIL async_reset got %b want %b", got, obs_t'(0));
        else n_pass++;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        rst = 1'b0;
        ec  = 0;
        model_reset();
        // button held across reset must be re-qualified for DEBOUNCE_MS ms
        while (ec < 40) begin
            predict(ec == 31);
            tick();
            got = sample(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want)
                $display("FAIL post_reset edge %0d got %b want %b", ec, got, want);
            else n_pass++;
        end
    endtask

    initial begin
        ec       = 0;
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        test_reset();
        test_ticks();
        test_free();
        test_halt_free();
        test_slow();
        test_step_debounce();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
